// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants and loader FSM encoding for the DT image pipeline
package dt_pkg;

  localparam int IMG_W       = 128;
  localparam int IMG_H       = 128;
  localparam int STI_AW      = 10;
  localparam int STI_DW      = 16;
  localparam int RES_AW      = 14;
  localparam int RES_DW      = 8;
  localparam int N_STI_WORDS = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } loader_state_t;

endpackage

// File: rtl/sti_res_loader.sv
// rtl/sti_res_loader.sv - streams packed sti_ROM words into res_RAM as one byte per pixel
module sti_res_loader
  import dt_pkg::*;
#(
  parameter logic [RES_DW-1:0] FG_VAL    = 8'h01,
  parameter bit                SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [STI_DW-1:0] sti_di,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [RES_DW-1:0] res_do
);

  localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(N_STI_WORDS - 1);

  loader_state_t     state, state_n;
  logic [STI_AW-1:0] word_cnt, word_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [STI_DW-1:0] shreg, shreg_n;

  // Termination compares before incrementing, so word_cnt never wraps into a write.
  always_comb begin
    state_n = state;
    word_n  = word_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          word_n  = '0;
        end
      end
      FETCH: begin
        shreg_n = sti_di;
        bit_n   = '0;
        if (SKIP_ZERO && (sti_di == '0)) begin
          if (word_cnt == LAST_WORD) state_n = DONE;
          else                       word_n  = word_cnt + 1'b1;
        end else begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        shreg_n = {shreg[STI_DW-2:0], 1'b0};
        bit_n   = bit_cnt + 1'b1;
        if (bit_cnt == 4'hF) begin
          if (word_cnt == LAST_WORD) begin
            state_n = DONE;
          end else begin
            word_n  = word_cnt + 1'b1;
            state_n = FETCH;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sti_rd   <= 1'b0;
      sti_addr <= '0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      state    <= state_n;
      word_cnt <= word_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      sti_rd   <= (state_n == FETCH);
      res_wr   <= (state_n == WRITE);
      if (state_n == FETCH) sti_addr <= word_n;
      if (state_n == WRITE) begin
        res_addr <= {word_n, bit_n};
        res_do   <= shreg_n[STI_DW-1] ? FG_VAL : '0;
      end
    end
  end

endmodule

// File: tb/tb_sti_res_loader.sv
// tb/tb_sti_res_loader.sv - scoreboard bench for sti_res_loader with ROM/RAM models
module tb_sti_res_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // DUT A: FG_VAL=01, every word written
  logic        reset_a, start_a, busy_a, done_a, sti_rd_a, res_wr_a;
  logic [9:0]  sti_addr_a;
  logic [15:0] sti_di_a = '0;
  logic [13:0] res_addr_a;
  logic [7:0]  res_do_a;
  logic [15:0] rom_a [1024];
  logic [7:0]  ram_a [16384];
  logic [21:0] exp_a [$];
  int          done_cnt_a = 0, wr_cnt_a = 0;

  // DUT B: FG_VAL=FF, zero words skipped
  logic        reset_b, start_b, busy_b, done_b, sti_rd_b, res_wr_b;
  logic [9:0]  sti_addr_b;
  logic [15:0] sti_di_b = '0;
  logic [13:0] res_addr_b;
  logic [7:0]  res_do_b;
  logic [15:0] rom_b [1024];
  logic [7:0]  ram_b [16384];
  logic [21:0] exp_b [$];
  int          wr_cnt_b = 0;
  logic [13:0] last_addr_b = '0;

  sti_res_loader #(.FG_VAL(8'h01), .SKIP_ZERO(1'b0)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_wr(res_wr_a), .res_addr(res_addr_a), .res_do(res_do_a));

  sti_res_loader #(.FG_VAL(8'hFF), .SKIP_ZERO(1'b1)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_wr(res_wr_b), .res_addr(res_addr_b), .res_do(res_do_b));

  // ROM models sample the address at negedge
  always @(negedge clk) if (sti_rd_a) sti_di_a <= rom_a[sti_addr_a];
  always @(negedge clk) if (sti_rd_b) sti_di_b <= rom_b[sti_addr_b];

  // Monitors: every RAM write is popped against the scoreboard and committed to the RAM model
  always @(negedge clk) begin
    automatic logic [21:0] e;
    if (res_wr_a) begin
      if (exp_a.size() == 0) check("a_unexpected_write", {18'd0, res_addr_a}, 32'hFFFF_FFFF);
      else begin
        e = exp_a.pop_front();
        check("a_wr_addr", {18'd0, res_addr_a}, {18'd0, e[21:8]});
        check("a_wr_data", {24'd0, res_do_a}, {24'd0, e[7:0]});
      end
      ram_a[res_addr_a] <= res_do_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  always @(negedge clk) begin
    automatic logic [21:0] e;
    if (res_wr_b) begin
      if (exp_b.size() == 0) check("b_unexpected_write", {18'd0, res_addr_b}, 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        check("b_wr_addr", {18'd0, res_addr_b}, {18'd0, e[21:8]});
        check("b_wr_data", {24'd0, res_do_b}, {24'd0, e[7:0]});
      end
      ram_b[res_addr_b] <= res_do_b;
      last_addr_b <= res_addr_b;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  // Reference: pixel p of word w lands at byte w*128/8... i.e. w*16+p, leftmost pixel first
  function automatic void push_a();
    for (int w = 0; w < 1024; w++)
      for (int p = 0; p < 16; p++)
        exp_a.push_back({14'(w * 16 + p), rom_a[w][15 - p] ? 8'h01 : 8'h00});
  endfunction

  function automatic void push_b();
    for (int w = 0; w < 1024; w++)
      if (rom_b[w] != 16'h0)
        for (int p = 0; p < 16; p++)
          exp_b.push_back({14'(w * 16 + p), rom_b[w][15 - p] ? 8'hFF : 8'h00});
  endfunction

  function automatic int image_errors_a();
    int bad = 0;
    for (int i = 0; i < 16384; i++)
      if (ram_a[i] !== (rom_a[i / 16][15 - (i % 16)] ? 8'h01 : 8'h00)) bad++;
    return bad;
  endfunction

  function automatic int image_errors_b();
    int bad = 0;
    for (int i = 0; i < 16384; i++)
      if (ram_b[i] !== (rom_b[i / 16][15 - (i % 16)] ? 8'hFF : 8'h00)) bad++;
    return bad;
  endfunction

  task automatic wait_a(input int budget, input int repulse_at, output int first, output int dn);
    first = -1;
    dn    = -1;
    for (int i = 0; i < budget && dn < 0; i++) begin
      if (sti_rd_a && first < 0) first = cyc;
      start_a = (repulse_at > 0 && first >= 0 && cyc == first + repulse_at);
      if (done_a) dn = cyc;
      if (dn < 0) begin @(posedge clk); #1; end
    end
    if (dn < 0) check("a_done_timeout", 0, 1);
  endtask

  task automatic wait_b(input int budget, output int first, output int dn);
    first = -1;
    dn    = -1;
    for (int i = 0; i < budget && dn < 0; i++) begin
      if (sti_rd_b && first < 0) first = cyc;
      if (done_b) dn = cyc;
      if (dn < 0) begin @(posedge clk); #1; end
    end
    if (dn < 0) check("b_done_timeout", 0, 1);
  endtask

  task automatic proc_a();
    int first, dn, wr0, hit;
    logic [7:0] old114, new113;
    foreach (rom_a[w]) rom_a[w] = 16'($urandom);
    rom_a[0] = 16'h8001;
    exp_a.delete();
    push_a();
    wr0 = wr_cnt_a;
    start_a = 1'b1;
    @(posedge clk); #1;
    wait_a(20000, 500, first, dn);
    check("a_latency", dn - first, 17408);
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; end
    check("a_single_done", done_cnt_a, 1);
    check("a_write_count", wr_cnt_a - wr0, 16384);
    check("a_queue_drained", exp_a.size(), 0);
    check("a_busy_after", {31'd0, busy_a}, 0);
    check("a_image_errors", image_errors_a(), 0);
    check("a_word0_px0", {24'd0, ram_a[0]}, 32'h01);
    check("a_word0_px15", {24'd0, ram_a[15]}, 32'h01);
    check("a_word0_px7", {24'd0, ram_a[7]}, 32'h00);

    // abort in the third write cycle of word 7, then reload from word 0
    old114 = rom_a[7][13] ? 8'h01 : 8'h00;
    foreach (rom_a[w]) rom_a[w] = 16'($urandom);
    new113 = rom_a[7][14] ? 8'h01 : 8'h00;
    exp_a.delete();
    push_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (res_wr_a && res_addr_a == 14'd114) hit = 1;
      else begin @(posedge clk); #1; end
    end
    check("a_reached_word7", hit, 1);
    #1 reset_a = 1'b0;
    #1;
    check("a_abort_outputs", {busy_a, done_a, sti_rd_a, sti_addr_a, res_wr_a, res_addr_a, res_do_a}, 0);
    exp_a.delete();
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("a_abort_kept_113", {24'd0, ram_a[113]}, {24'd0, new113});
    check("a_abort_old_114", {24'd0, ram_a[114]}, {24'd0, old114});
    reset_a = 1'b1;
    @(posedge clk); #1;
    push_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    check("a_restart_addr", {22'd0, sti_addr_a}, 0);
    wait_a(20000, 0, first, dn);
    check("a_reload_latency", dn - first, 17408);
    @(posedge clk); #1;
    check("a_reload_image_errors", image_errors_a(), 0);
    check("a_reload_queue_drained", exp_a.size(), 0);
  endtask

  task automatic proc_b();
    int first, dn, wr0, nz;
    foreach (rom_b[w]) rom_b[w] = 16'h0;
    rom_b[5] = 16'hA5A5;
    push_b();
    wr0 = wr_cnt_b;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_b(5000, first, dn);
    check("b_sparse_latency", dn - first, 1040);
    check("b_sparse_writes", wr_cnt_b - wr0, 16);
    check("b_sparse_last_addr", {18'd0, last_addr_b}, 95);
    @(posedge clk); #1;
    check("b_sparse_image_errors", image_errors_b(), 0);
    check("b_px80", {24'd0, ram_b[80]}, 32'hFF);
    check("b_px81", {24'd0, ram_b[81]}, 32'h00);

    // random sparse image ending in an all-ones word, start held across done
    for (int k = 0; k < 20; k++) rom_b[$urandom_range(1, 1022)] = 16'($urandom_range(1, 65535));
    rom_b[1023] = 16'hFFFF;
    nz = 0;
    foreach (rom_b[w]) if (rom_b[w] != 16'h0) nz++;
    push_b();
    wr0 = wr_cnt_b;
    start_b = 1'b1;
    @(posedge clk); #1;
    wait_b(20000, first, dn);
    check("b_rand_latency", dn - first, 1024 + 16 * nz);
    check("b_rand_writes", wr_cnt_b - wr0, 16 * nz);
    check("b_last_addr", {18'd0, last_addr_b}, 16383);
    check("b_done_busy", {31'd0, busy_b}, 1);
    push_b();
    @(posedge clk); #1;
    check("b_idle_busy", {31'd0, busy_b}, 0);
    check("b_idle_rd", {31'd0, sti_rd_b}, 0);
    check("b_idle_done", {31'd0, done_b}, 0);
    @(posedge clk); #1;
    check("b_reload_rd", {31'd0, sti_rd_b}, 1);
    check("b_reload_addr", {22'd0, sti_addr_b}, 0);
    start_b = 1'b0;
    wait_b(20000, first, dn);
    check("b_reload_latency", dn - first, 1024 + 16 * nz);
    @(posedge clk); #1;
    check("b_tail_ff", {24'd0, ram_b[16383]}, 32'hFF);
    check("b_rand_image_errors", image_errors_b(), 0);
    check("b_queue_drained", exp_b.size(), 0);
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    foreach (ram_a[i]) ram_a[i] = 8'h00;
    foreach (ram_b[i]) ram_b[i] = 8'h00;
    @(posedge clk); #1;
    start_a = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    check("a_reset_outputs", {busy_a, done_a, sti_rd_a, sti_addr_a, res_wr_a, res_addr_a, res_do_a}, 0);
    check("b_reset_outputs", {busy_b, done_b, sti_rd_b, sti_addr_b, res_wr_b, res_addr_b, res_do_b}, 0);
    start_a = 1'b0; start_b = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    @(posedge clk); #1;
    check("a_idle_after_reset", {31'd0, busy_a}, 0);
    fork
      proc_a();
      proc_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
